// File: rtl/processor_onchip_ram_pipelined_pkg.sv
// rtl/processor_onchip_ram_pipelined_pkg.sv - shared types and helpers for the pipelined on-chip RAM
package processor_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

  localparam int BYTE_W = 8;

  function automatic int lane_count(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/processor_onchip_ram_pipelined_if.sv
// rtl/processor_onchip_ram_pipelined_if.sv - Avalon-MM slave bus bundle for the on-chip RAM
interface processor_onchip_ram_pipelined_if
  import processor_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int LANES = lane_count(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] address;
  logic [LANES-1:0]      byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/processor_onchip_ram_pipelined_core.sv
// rtl/processor_onchip_ram_pipelined_core.sv - inferred single-port byte-enabled RAM with registered q
module processor_ram_core
  import processor_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                            clk,
  input  logic                            en,
  input  logic                            we,
  input  logic                            re,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [lane_count(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           q
);
  localparam int LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // q only moves on a real read so it can double as the latency-1 output hold register
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
      if (re) q <= mem[addr];
    end
  end
endmodule

// File: rtl/processor_onchip_ram_pipelined.sv
// rtl/processor_onchip_ram_pipelined.sv - Avalon-MM on-chip RAM slave with pipelined reads and zero-fill
module processor_onchip_ram_pipelined
  import processor_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               clken,
  input  logic                               reset_req,
  processor_onchip_ram_pipelined_if.slave    bus,
  output logic                               init_done
);
  localparam int                    LANES   = lane_count(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("DEPTH exceeds address space");
  end

  ram_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] fill_cnt, fill_nxt;
  logic                  active, in_range, acc_rd, acc_wr;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [LANES-1:0]      ram_be;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_q;
  logic                  v1, z1;

  assign active   = clken & ~reset_req;
  assign in_range = {1'b0, bus.address} < DEPTH_W;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    fill_nxt        = fill_cnt;
    bus.waitrequest = ~(active && state == RUN);
    init_done       = (state == RUN);
    acc_rd          = active && state == RUN && bus.chipselect && bus.read && !bus.write;
    acc_wr          = active && state == RUN && bus.chipselect && bus.write;
    ram_addr        = bus.address;
    ram_be          = bus.byteenable;
    ram_wdata       = bus.writedata;
    ram_we          = acc_wr && in_range;
    ram_re          = acc_rd && in_range;
    if (state == INIT) begin
      ram_addr  = fill_cnt;
      ram_be    = '1;
      ram_wdata = '0;
      ram_we    = (CLEAR_ON_RESET != 0);
      if (active) begin
        if (CLEAR_ON_RESET == 0 || fill_cnt == LAST) begin
          state_nxt = RUN;
          fill_nxt  = '0;
        end else begin
          fill_nxt = fill_cnt + 1'b1;
        end
      end
    end
  end

  processor_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk   (clk),
    .en    (active),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // z1 masks q for out-of-range reads and keeps readdata at zero until the first read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      z1 <= 1'b1;
    end else if (active) begin
      v1 <= acc_rd;
      if (acc_rd) z1 <= ~in_range;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.readdata      = z1 ? '0 : ram_q;
    assign bus.readdatavalid = v1 & active;
  end else begin : g_lat2
    logic                  v2;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2     <= 1'b0;
        data_q <= '0;
      end else if (active) begin
        v2 <= v1;
        if (v1) data_q <= z1 ? '0 : ram_q;
      end
    end

    assign bus.readdata      = data_q;
    assign bus.readdatavalid = v2 & active;
  end
endmodule

// File: tb/tb_processor_onchip_ram_pipelined.sv
// tb/tb_processor_onchip_ram_pipelined.sv - scoreboard bench for the pipelined on-chip RAM
module tb_processor_onchip_ram_pipelined;

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic clken_a = 1'b1, rreq_a = 1'b0, clken_b = 1'b1, rreq_b = 1'b0;
  logic init_a, init_b;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  exp_t qa[$], qb[$];
  int   a_vcyc[$];

  processor_onchip_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  aif ();
  processor_onchip_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bif ();

  processor_onchip_ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .clken(clken_a), .reset_req(rreq_a), .bus(aif), .init_done(init_a)
  );

  processor_onchip_ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .clken(clken_b), .reset_req(rreq_b), .bus(bif), .init_done(init_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_a && aif.readdatavalid) begin
      a_vcyc.push_back(cyc);
      if (qa.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        check("a_readdata", aif.readdata, e.data);
        if (e.chk) check("a_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (rst_b && bif.readdatavalid) begin
      if (qb.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        check("b_readdata", bif.readdata, e.data);
        if (e.chk) check("b_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic idle(input bit b);
    if (b) begin bif.chipselect = 0; bif.read = 0; bif.write = 0; end
    else   begin aif.chipselect = 0; aif.read = 0; aif.write = 0; end
  endtask

  // Drives one request and returns just after the edge that accepts it; signals stay asserted.
  task automatic bus(input bit b, input bit rd, input bit wr, input int addr, input logic [3:0] be,
                     input logic [31:0] d, input logic [31:0] exp, input bit chk_lat);
    bit   acc = 0;
    logic wq;
    exp_t e;
    if (b) begin
      bif.chipselect = 1; bif.read = rd; bif.write = wr;
      bif.address = 10'(addr); bif.byteenable = be; bif.writedata = d;
    end else begin
      aif.chipselect = 1; aif.read = rd; aif.write = wr;
      aif.address = 4'(addr); aif.byteenable = be; aif.writedata = d;
    end
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      wq = b ? bif.waitrequest : aif.waitrequest;
      if (!wq) begin
        acc = 1;
        if (rd && !wr) begin
          e.data = exp; e.due = cyc + (b ? 1 : 2); e.chk = chk_lat;
          if (b) qb.push_back(e); else qa.push_back(e);
        end
        break;
      end
    end
    if (!acc) check("bus_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_init(input bit b, output int n);
    logic wq;
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      wq = b ? bif.waitrequest : aif.waitrequest;
      if (!wq) break;
      n++;
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_readdata"}, aif.readdata, 32'h0);
    check({tag, "_readdatavalid"}, 32'(aif.readdatavalid), 32'd0);
    check({tag, "_waitrequest"}, 32'(aif.waitrequest), 32'd1);
    check({tag, "_init_done"}, 32'(init_a), 32'd0);
  endtask

  logic [31:0] burst [8] = '{32'h0, 32'h55AA55AA, 32'h11223344, 32'h0,
                             32'h0, 32'hDEADBEAA, 32'h00000066, 32'hCAFE0000};

  initial begin
    int n, base, last;
    idle(0); idle(1);
    aif.address = '0; aif.byteenable = '0; aif.writedata = '0;
    bif.address = '0; bif.byteenable = '0; bif.writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("reset");
    rst_a = 1;

    // fill takes exactly DEPTH active cycles, then everything reads zero
    wait_init(0, n);
    check("a_init_cycles", 32'(n), 32'd16);
    check("a_init_done", 32'(init_a), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) bus(0, 1, 0, i, 4'hF, 0, 32'h0, 1);
    idle(0);

    bus(0, 0, 1, 5, 4'hF, 32'hDEADBEEF, 0, 0);
    bus(0, 0, 1, 5, 4'h1, 32'h000000AA, 0, 0);
    bus(0, 1, 0, 5, 4'hF, 0, 32'hDEADBEAA, 1);
    bus(0, 1, 1, 6, 4'hF, 32'h00000066, 0, 0);
    bus(0, 0, 1, 2, 4'hF, 32'h11223344, 0, 0);
    bus(0, 0, 1, 7, 4'hC, 32'hCAFEF00D, 0, 0);
    bus(0, 0, 1, 1, 4'hF, 32'h55AA55AA, 0, 0);
    bus(0, 1, 0, 1, 4'hF, 0, 32'h55AA55AA, 1);
    idle(0);
    repeat (4) @(posedge clk);
    #1;

    base = a_vcyc.size();
    for (int i = 0; i < 8; i++) bus(0, 1, 0, i, 4'hF, 0, burst[i], 1);
    idle(0);
    repeat (5) @(negedge clk);
    check("burst_pulse_count", 32'(a_vcyc.size() - base), 32'd8);
    if (a_vcyc.size() - base == 8) begin
      last = a_vcyc.size() - 1;
      check("burst_no_gaps", 32'(a_vcyc[last] - a_vcyc[last-7]), 32'd7);
    end
    @(posedge clk); #1;

    // clken stall in the middle of a burst
    for (int i = 0; i < 4; i++) bus(0, 1, 0, i, 4'hF, 0, burst[i], 0);
    aif.address = 4'd4;
    clken_a = 0;
    repeat (3) begin
      @(negedge clk);
      check("stall_readdatavalid", 32'(aif.readdatavalid), 32'd0);
      check("stall_waitrequest", 32'(aif.waitrequest), 32'd1);
      @(posedge clk); #1;
    end
    clken_a = 1;
    for (int i = 4; i < 8; i++) bus(0, 1, 0, i, 4'hF, 0, burst[i], 0);
    idle(0);
    rreq_a = 1;
    @(negedge clk);
    check("reset_req_waitrequest", 32'(aif.waitrequest), 32'd1);
    @(posedge clk); #1;
    rreq_a = 0;
    repeat (6) @(posedge clk);
    #1;
    check("a_queue_drained", 32'(qa.size()), 32'd0);

    // reset in the middle of the fill restarts it from address 0
    bus(0, 0, 1, 3, 4'hF, 32'h12345678, 0, 0);
    bus(0, 1, 0, 3, 4'hF, 0, 32'h12345678, 1);
    idle(0);
    repeat (4) @(posedge clk);
    #1;
    rst_a = 0;
    @(posedge clk); #1;
    rst_a = 1;
    repeat (7) @(posedge clk);
    #1;
    rst_a = 0;
    #1;
    check_reset_a("abort");
    @(posedge clk); #1;
    rst_a = 1;
    wait_init(0, n);
    check("a_refill_cycles", 32'(n), 32'd16);
    @(posedge clk); #1;
    bus(0, 1, 0, 3, 4'hF, 0, 32'h0, 1);
    idle(0);

    // DEPTH=1000, latency 1, out-of-range handling
    rst_b = 1;
    wait_init(1, n);
    check("b_init_cycles", 32'(n), 32'd1000);
    check("b_init_done", 32'(init_b), 32'd1);
    @(posedge clk); #1;
    bus(1, 0, 1, 5, 4'hF, 32'hDEADBEEF, 0, 0);
    bus(1, 0, 1, 5, 4'h1, 32'h000000AA, 0, 0);
    bus(1, 1, 0, 5, 4'hF, 0, 32'hDEADBEAA, 1);
    bus(1, 0, 1, 1010, 4'hF, 32'hFFFFFFFF, 0, 0);
    bus(1, 1, 0, 1010, 4'hF, 0, 32'h0, 1);
    bus(1, 1, 0, 10, 4'hF, 0, 32'h0, 1);
    bus(1, 0, 1, 999, 4'hF, 32'hA5A5A5A5, 0, 0);
    bus(1, 1, 0, 999, 4'hF, 0, 32'hA5A5A5A5, 1);
    idle(1);
    repeat (4) @(posedge clk);
    #1;
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
